// File: rtl/id_ex_skid_reg_if.sv
// Decode/execute stage handshake bundle: valid/ready plus the ID->EX payload fields.
// The producer side uses the master modport, the consumer side uses slave.
interface id_ex_skid_reg_if #(
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int CTRL_BITS    = 32
);
  logic                    valid;
  logic                    ready;
  logic [CTRL_BITS-1:0]    ctrl;
  logic [4:0]              rs1;
  logic [4:0]              rs2;
  logic [DATA_WIDTH-1:0]   rs1_data;
  logic [DATA_WIDTH-1:0]   rs2_data;
  logic [ADDRESS_BITS-1:0] inst_PC;
  logic [ADDRESS_BITS-1:0] target;
  logic [DATA_WIDTH-1:0]   extend_imm;

  modport master (
    output valid, ctrl, rs1, rs2, rs1_data, rs2_data, inst_PC, target, extend_imm,
    input  ready
  );

  modport slave (
    input  valid, ctrl, rs1, rs2, rs1_data, rs2_data, inst_PC, target, extend_imm,
    output ready
  );
endinterface

// File: rtl/id_ex_skid_reg.sv
// Two-entry ID/EX pipeline register with skid buffer; id.ready depends only on registered state.
// Optional macro ID_EX_WB_BYPASS_EN: write-back snoop refreshes held rs1/rs2 data.
module id_ex_skid_reg #(
  parameter int CORE         = 0,
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int CTRL_BITS    = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  id_ex_skid_reg_if.slave       id,
  id_ex_skid_reg_if.master      ex,
  input  logic                  flush,
  input  logic                  wb_write,
  input  logic [4:0]            wb_write_reg,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_BITS-1:0]    ctrl;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [DATA_WIDTH-1:0]   rs1_data;
    logic [DATA_WIDTH-1:0]   rs2_data;
    logic [ADDRESS_BITS-1:0] inst_pc;
    logic [ADDRESS_BITS-1:0] target;
    logic [DATA_WIDTH-1:0]   extend_imm;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   retire;

`ifdef ID_EX_WB_BYPASS_EN
  // Register x0 is hardwired zero, so a write to it never refreshes operands.
  function automatic entry_t wb_fwd(entry_t e, logic we, logic [4:0] wreg,
                                    logic [DATA_WIDTH-1:0] wdata);
    entry_t r;
    r = e;
    if (we && (wreg != 5'd0)) begin
      if (e.rs1 == wreg) r.rs1_data = wdata;
      if (e.rs2 == wreg) r.rs2_data = wdata;
    end
    return r;
  endfunction
`endif

  assign in_entry = '{
    ctrl:       id.ctrl,
    rs1:        id.rs1,
    rs2:        id.rs2,
    rs1_data:   id.rs1_data,
    rs2_data:   id.rs2_data,
    inst_pc:    id.inst_PC,
    target:     id.target,
    extend_imm: id.extend_imm
  };

  assign id.ready  = (state_q != TWO);
  assign ex.valid  = (state_q != EMPTY);
  assign occupancy = state_q;
  assign accept    = id.valid & id.ready;
  assign retire    = ex.valid & ex.ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && retire) begin
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = TWO;
        end else if (retire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (retire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
`ifdef ID_EX_WB_BYPASS_EN
    // Applied after the move/capture selection so held, moved and incoming entries all see it.
    main_d = wb_fwd(main_d, wb_write, wb_write_reg, wb_write_data);
    skid_d = wb_fwd(skid_d, wb_write, wb_write_reg, wb_write_data);
`endif
    if (flush) state_d = EMPTY;
  end

  // NOTE: payload registers are reset too so ex_* read as zero while reset is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign ex.ctrl       = main_q.ctrl;
  assign ex.rs1        = main_q.rs1;
  assign ex.rs2        = main_q.rs2;
  assign ex.rs1_data   = main_q.rs1_data;
  assign ex.rs2_data   = main_q.rs2_data;
  assign ex.inst_PC    = main_q.inst_pc;
  assign ex.target     = main_q.target;
  assign ex.extend_imm = main_q.extend_imm;

  // Sink for inputs/parameters that carry no function in some builds.
  logic unused_sink;
  assign unused_sink = &{1'b0, CORE[0], wb_write, wb_write_reg, wb_write_data};

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed self-checking bench for id_ex_skid_reg: stream, backpressure, flush, async reset
// and write-back snoop, with expectations following the ID_EX_WB_BYPASS_EN setting.
module tb_id_ex_skid_reg;

  localparam int AB = 20;
  localparam int DW = 32;
  localparam int CB = 32;
`ifdef ID_EX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          wb_write = 1'b0;
  logic [4:0]    wb_write_reg = 5'd0;
  logic [DW-1:0] wb_write_data = '0;
  logic [1:0]    occupancy;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_skid_reg_if #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .CTRL_BITS(CB)) id_bus ();
  id_ex_skid_reg_if #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .CTRL_BITS(CB)) ex_bus ();

  id_ex_skid_reg #(.CORE(0), .ADDRESS_BITS(AB), .DATA_WIDTH(DW), .CTRL_BITS(CB)) dut (
    .clock         (clock),
    .reset         (reset),
    .id            (id_bus),
    .ex            (ex_bus),
    .flush         (flush),
    .wb_write      (wb_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .occupancy     (occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [1:0] occ,
                           input logic rdy);
    chk({tag, ".ex_valid"},  32'(ex_bus.valid), 32'(v));
    chk({tag, ".occupancy"}, 32'(occupancy),    32'(occ));
    chk({tag, ".id_ready"},  32'(id_bus.ready), 32'(rdy));
  endtask

  // Payload fields are derived from the PC so a PC check implies which entry is on ex_*.
  task automatic put(input logic v, input logic [AB-1:0] pc);
    id_bus.valid      = v;
    id_bus.inst_PC    = pc;
    id_bus.ctrl       = 32'hA500_0000 ^ 32'(pc);
    id_bus.rs1        = pc[4:0];
    id_bus.rs2        = ~pc[4:0];
    id_bus.rs1_data   = 32'h1000_0000 + 32'(pc);
    id_bus.rs2_data   = 32'h2000_0000 + 32'(pc);
    id_bus.target     = pc + 20'h100;
    id_bus.extend_imm = 32'hFFFF_0000 ^ 32'(pc);
  endtask

  task automatic chk_entry(input string tag, input logic [AB-1:0] pc);
    chk({tag, ".inst_PC"},  32'(ex_bus.inst_PC),  32'(pc));
    chk({tag, ".ctrl"},     ex_bus.ctrl,          32'hA500_0000 ^ 32'(pc));
    chk({tag, ".rs1_data"}, ex_bus.rs1_data,      32'h1000_0000 + 32'(pc));
    chk({tag, ".target"},   32'(ex_bus.target),   32'(pc + 20'h100));
    chk({tag, ".imm"},      ex_bus.extend_imm,    32'hFFFF_0000 ^ 32'(pc));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    put(1'b0, '0);
    ex_bus.ready = 1'b0;

    // Asynchronous reset from power-up.
    #2 reset = 1'b0;
    #1;
    chk_state("reset", 1'b0, 2'd0, 1'b1);
    chk("reset.inst_PC", 32'(ex_bus.inst_PC), 32'h0);
    chk("reset.rs1_data", ex_bus.rs1_data, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Continuous stream: one-cycle latency, occupancy steady at 1.
    ex_bus.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put(1'b1, AB'(i));
      tick();
      chk($sformatf("stream%0d.inst_PC", i), 32'(ex_bus.inst_PC), 32'(i));
      chk_state($sformatf("stream%0d", i), 1'b1, 2'd1, 1'b1);
    end
    put(1'b0, '0);
    tick();
    chk_state("drain", 1'b0, 2'd0, 1'b1);

    // Backpressure into the skid entry, then drain in order.
    ex_bus.ready = 1'b0;
    put(1'b1, 20'h10);
    tick();
    chk_state("bp1", 1'b1, 2'd1, 1'b1);
    chk_entry("bp1", 20'h10);
    put(1'b1, 20'h14);
    tick();
    chk_state("bp2", 1'b1, 2'd2, 1'b0);
    chk_entry("bp2", 20'h10);
    put(1'b1, 20'h18);
    tick();
    chk_state("bp_full", 1'b1, 2'd2, 1'b0);
    chk("bp_full.inst_PC", 32'(ex_bus.inst_PC), 32'h10);
    put(1'b0, '0);
    ex_bus.ready = 1'b1;
    tick();
    chk_state("bp_move", 1'b1, 2'd1, 1'b1);
    chk_entry("bp_move", 20'h14);
    tick();
    chk_state("bp_empty", 1'b0, 2'd0, 1'b1);

    // ONE with simultaneous accept and retire stays ONE with the new entry.
    put(1'b1, 20'h20);
    tick();
    put(1'b1, 20'h24);
    tick();
    chk_state("ar", 1'b1, 2'd1, 1'b1);
    chk("ar.inst_PC", 32'(ex_bus.inst_PC), 32'h24);

    // Flush in TWO overrides same-cycle accept and retire.
    ex_bus.ready = 1'b0;
    put(1'b1, 20'h30);
    tick();
    chk_state("pre_flush", 1'b1, 2'd2, 1'b0);
    flush = 1'b1;
    ex_bus.ready = 1'b1;
    put(1'b1, 20'h34);
    tick();
    chk_state("flush_two", 1'b0, 2'd0, 1'b1);
    flush = 1'b0;
    ex_bus.ready = 1'b0;
    put(1'b1, 20'h38);
    tick();
    chk_state("post_flush", 1'b1, 2'd1, 1'b1);
    chk("post_flush.inst_PC", 32'(ex_bus.inst_PC), 32'h38);
    flush = 1'b1;
    put(1'b1, 20'h3C);
    tick();
    chk_state("flush_one", 1'b0, 2'd0, 1'b1);
    flush = 1'b0;
    put(1'b0, '0);

    // Reset asserted between edges while holding two entries.
    put(1'b1, 20'h50);
    tick();
    put(1'b1, 20'h54);
    tick();
    chk_state("pre_rst", 1'b1, 2'd2, 1'b0);
    put(1'b0, '0);
    #2 reset = 1'b0;
    #1;
    chk_state("mid_rst", 1'b0, 2'd0, 1'b1);
    chk("mid_rst.inst_PC", 32'(ex_bus.inst_PC), 32'h0);
    chk("mid_rst.rs1_data", ex_bus.rs1_data, 32'h0);
    chk("mid_rst.ctrl", ex_bus.ctrl, 32'h0);
    #3 reset = 1'b1;
    ex_bus.ready = 1'b1;
    put(1'b1, 20'h60);
    tick();
    chk_state("after_rst", 1'b1, 2'd1, 1'b1);
    chk_entry("after_rst", 20'h60);
    put(1'b0, '0);
    tick();

    // Write-back snoop on held main entry, x0 write, and incoming skid capture.
    ex_bus.ready = 1'b0;
    put(1'b1, 20'h70);
    id_bus.rs1 = 5'd5;  id_bus.rs1_data = 32'h1;
    id_bus.rs2 = 5'd7;  id_bus.rs2_data = 32'h2;
    tick();
    chk("byp_load.rs1_data", ex_bus.rs1_data, 32'h1);
    put(1'b0, '0);
    wb_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'hDEAD;
    tick();
    chk("byp_main.rs1_data", ex_bus.rs1_data, BYP ? 32'hDEAD : 32'h1);
    chk("byp_main.rs2_data", ex_bus.rs2_data, 32'h2);
    wb_write_reg = 5'd0; wb_write_data = 32'hBEEF;
    tick();
    chk("byp_x0.rs1_data", ex_bus.rs1_data, BYP ? 32'hDEAD : 32'h1);
    put(1'b1, 20'h74);
    id_bus.rs1 = 5'd9;  id_bus.rs1_data = 32'h4;
    id_bus.rs2 = 5'd5;  id_bus.rs2_data = 32'h3;
    wb_write_reg = 5'd5; wb_write_data = 32'hCAFE;
    tick();
    chk_state("byp_two", 1'b1, 2'd2, 1'b0);
    chk("byp_two.rs1_data", ex_bus.rs1_data, BYP ? 32'hCAFE : 32'h1);
    wb_write = 1'b0;
    put(1'b0, '0);
    ex_bus.ready = 1'b1;
    tick();
    chk("byp_skid.inst_PC", 32'(ex_bus.inst_PC), 32'h74);
    chk("byp_skid.rs1_data", ex_bus.rs1_data, 32'h4);
    chk("byp_skid.rs2_data", ex_bus.rs2_data, BYP ? 32'hCAFE : 32'h3);
    tick();
    chk_state("end", 1'b0, 2'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_skid_reg.md
ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

Interface
REQ-001 SHALL have parameter CORE, default 0, core index for multi-core instantiation; no functional effect.
REQ-002 SHALL have parameter ADDRESS_BITS, default 20, width of PC/target fields.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, width of register data and immediate.
REQ-004 SHALL have parameter CTRL_BITS, default 32, width of opaque control bundle (opcode, funct3, funct7, rd, branch, extend_sel, next_PC_select).
REQ-005 SHALL have port clock  input  1  single clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports id_valid input 1 / id_ready output 1: upstream (decode) handshake.
REQ-008 SHALL have inputs id_ctrl [CTRL_BITS], id_rs1 [5], id_rs2 [5], id_rs1_data [DATA_WIDTH], id_rs2_data [DATA_WIDTH], id_inst_PC [ADDRESS_BITS], id_target [ADDRESS_BITS], id_extend_imm [DATA_WIDTH]: decode payload.
REQ-009 SHALL have ports ex_valid output 1 / ex_ready input 1: downstream (execute) handshake.
REQ-010 SHALL have outputs ex_ctrl, ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data, ex_inst_PC, ex_target, ex_extend_imm, widths matching REQ-008.
REQ-011 SHALL have port flush  input  1  discard all held entries.
REQ-012 SHALL have inputs wb_write 1, wb_write_reg 5, wb_write_data DATA_WIDTH: register-file write port snoop.
REQ-013 SHALL have output occupancy [2]: number of held entries (0..2).

Function
REQ-014 SHALL hold two entries: main (drives ex_* outputs) and skid; state EMPTY (0), ONE (main), TWO (main+skid).
REQ-015 SHALL drive id_ready = 1 in EMPTY and ONE, 0 in TWO, from registered state only (no combinational path from ex_ready).
REQ-016 SHALL drive ex_valid = 1 in ONE and TWO; ex_* payload = main entry.
REQ-017 SHALL accept input when id_valid & id_ready; SHALL retire main when ex_valid & ex_ready.
REQ-018 EMPTY: accept -> ONE (input into main); no accept -> EMPTY.
REQ-019 ONE: accept & retire -> ONE (input into main); accept only -> TWO (input into skid); retire only -> EMPTY; neither -> ONE.
REQ-020 TWO: retire -> ONE (skid moves into main); no retire -> TWO, all held.
REQ-021 SHALL have latency 1 cycle: entry accepted at edge N visible on ex_* after edge N; order preserved, no loss or duplication.
REQ-022 flush SHALL force EMPTY at next edge, overriding simultaneous accept and retire; payload registers need not clear; id_ready = 1 the following cycle.
REQ-023 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO.
REQ-024 Payload SHALL be stored bit-exact except as modified by REQ-027.

Reset
REQ-025 On reset low, state SHALL go EMPTY immediately (asynchronous): ex_valid 0, occupancy 0, id_ready 1, all payload registers 0.
REQ-026 Reset asserted mid-transfer SHALL drop all entries; first accept after reset release behaves as from EMPTY.

Configuration
REQ-027 With macro ID_EX_WB_BYPASS_EN defined: when wb_write=1 and wb_write_reg != 0, any held or same-cycle-captured entry whose rs1 (rs2) equals wb_write_reg SHALL have rs1_data (rs2_data) replaced by wb_write_data at that edge; applies to main, skid, skid->main move, and incoming capture; x0 never updated.
REQ-028 Without ID_EX_WB_BYPASS_EN: wb_* inputs SHALL be ignored and payload held unchanged.

Verification
REQ-029 Stream: ex_ready=1, id_valid=1 for 8 cycles, id_inst_PC=0..7 -> ex_inst_PC 0..7 one cycle later, occupancy 1, id_ready stays 1.
REQ-030 Backpressure: ex_ready=0, send PC 0x10, 0x14 -> occupancy 2, id_ready 0; ex_ready=1 -> 0x10 then 0x14 out, no loss.
REQ-031 Flush in TWO with id_valid=1 and ex_ready=1 same cycle -> next cycle ex_valid 0, occupancy 0, id_ready 1.
REQ-032 Reset low mid-TWO between edges -> ex_valid 0, ex_* 0 immediately, before next clock.
REQ-033 Bypass on: held entry rs1=5, rs1_data=0x1, wb_write=1 reg 5 data 0xDEAD -> ex_rs1_data 0xDEAD; wb reg 0 -> unchanged; bypass off -> stays 0x1.
